// File: rtl/hs_tx_sequencer.sv
// D-PHY HS transmit lane sequencer: LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync -> payload -> trail -> exit.
// Every output is a flop whose next value is decoded from the next state and the next data register.
module hs_tx_sequencer #(
    parameter int unsigned T_LPX_CYC   = 2,
    parameter int unsigned T_PREP_CYC  = 2,
    parameter int unsigned T_ZERO_CYC  = 4,
    parameter int unsigned T_TRAIL_CYC = 2,
    parameter int unsigned T_EXIT_CYC  = 3
) (
    input  logic       TxByteClkHS,
    input  logic       TxRst_n,
    input  logic       TxRequestHS,
    input  logic [7:0] TxDataHS,
    output logic       TxReadyHS,
    output logic [7:0] TxByteHS_Data,
    output logic       Serializer_Enable,
    output logic       HsDriveEn,
    output logic       LpDp,
    output logic       LpDn,
    output logic       Stopstate
);

    typedef enum logic [2:0] {
        IDLE, LP01, LP00, HS_ZERO, SYNC, DATA, TRAIL, EXIT
    } state_t;

    // Counter load value is duration-1; a zero duration behaves as one cycle.
    function automatic logic [7:0] cyc_load(input int unsigned t);
        if (t == 0)
            return 8'd0;
        else if (t > 255)
            return 8'd254;
        else
            return 8'(t - 1);
    endfunction

    localparam logic [7:0] LPX_LOAD   = cyc_load(T_LPX_CYC);
    localparam logic [7:0] PREP_LOAD  = cyc_load(T_PREP_CYC);
    localparam logic [7:0] ZERO_LOAD  = cyc_load(T_ZERO_CYC);
    localparam logic [7:0] TRAIL_LOAD = cyc_load(T_TRAIL_CYC);
    localparam logic [7:0] EXIT_LOAD  = cyc_load(T_EXIT_CYC);
    localparam logic [7:0] SYNC_BYTE  = 8'hB8;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] last_q, last_d;

    logic       ready_q, ready_d;
    logic [7:0] byte_q, byte_d;
    logic       ser_q, ser_d;
    logic       hs_q, hs_d;
    logic       lpdp_q, lpdp_d;
    logic       lpdn_q, lpdn_d;
    logic       stop_q, stop_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (TxRequestHS) begin
                    state_d = LP01;
                    cnt_d   = LPX_LOAD;
                end
            end
            LP01: begin
                if (cnt_q == 8'd0) begin
                    state_d = LP00;
                    cnt_d   = PREP_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            LP00: begin
                if (cnt_q == 8'd0) begin
                    state_d = HS_ZERO;
                    cnt_d   = ZERO_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            HS_ZERO: begin
                if (cnt_q == 8'd0) begin
                    state_d = SYNC;
                    cnt_d   = 8'd0;
                    last_d  = SYNC_BYTE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SYNC, DATA: begin
                // The sync cycle already shows TxReadyHS, so its edge can take the first payload byte.
                if (TxRequestHS) begin
                    state_d = DATA;
                    last_d  = TxDataHS;
                end else begin
                    state_d = TRAIL;
                    cnt_d   = TRAIL_LOAD;
                end
            end
            TRAIL: begin
                if (cnt_q == 8'd0) begin
                    state_d = EXIT;
                    cnt_d   = EXIT_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            EXIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Output decode of the upcoming state, so the registered outputs line up with state_q.
    always_comb begin
        ready_d = 1'b0;
        byte_d  = 8'h00;
        ser_d   = 1'b0;
        hs_d    = 1'b0;
        lpdp_d  = 1'b0;
        lpdn_d  = 1'b0;
        stop_d  = 1'b0;
        case (state_d)
            IDLE: begin
                lpdp_d = 1'b1;
                lpdn_d = 1'b1;
                stop_d = 1'b1;
            end
            LP01: lpdn_d = 1'b1;
            LP00: ;
            HS_ZERO: begin
                ser_d = 1'b1;
                hs_d  = 1'b1;
            end
            SYNC, DATA: begin
                ser_d   = 1'b1;
                hs_d    = 1'b1;
                ready_d = 1'b1;
                byte_d  = last_d;
            end
            TRAIL: begin
                ser_d  = 1'b1;
                hs_d   = 1'b1;
                byte_d = last_d[7] ? 8'h00 : 8'hFF;
            end
            EXIT: begin
                lpdp_d = 1'b1;
                lpdn_d = 1'b1;
            end
            default: begin
                lpdp_d = 1'b1;
                lpdn_d = 1'b1;
                stop_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge TxByteClkHS or negedge TxRst_n) begin
        if (!TxRst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            last_q  <= 8'h00;
            ready_q <= 1'b0;
            byte_q  <= 8'h00;
            ser_q   <= 1'b0;
            hs_q    <= 1'b0;
            lpdp_q  <= 1'b1;
            lpdn_q  <= 1'b1;
            stop_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            ready_q <= ready_d;
            byte_q  <= byte_d;
            ser_q   <= ser_d;
            hs_q    <= hs_d;
            lpdp_q  <= lpdp_d;
            lpdn_q  <= lpdn_d;
            stop_q  <= stop_d;
        end
    end

    assign TxReadyHS         = ready_q;
    assign TxByteHS_Data     = byte_q;
    assign Serializer_Enable = ser_q;
    assign HsDriveEn         = hs_q;
    assign LpDp              = lpdp_q;
    assign LpDn              = lpdn_q;
    assign Stopstate         = stop_q;

endmodule
